// File: rtl/fifo_share_arbiter.sv
// fifo_share_arbiter
//   Round-robin push arbiter in front of one shared FIFO. It limits how many
//   entries each requester may hold (QUOTA) and keeps a tag queue that mirrors
//   the FIFO, so the consumer knows which requester owns the head entry.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   req          per-requester push request
//   req_data     requester i data at [i*WIDTH +: WIDTH]
//   gnt          one-hot-or-zero grant (combinational)
//   fifo_push    push strobe to the shared FIFO
//   fifo_data    data of the granted requester, 0 when nothing is granted
//   fifo_full    full flag from the shared FIFO
//   fifo_empty   empty flag from the shared FIFO
//   pop          consumer pop request
//   fifo_pop     pop strobe to the shared FIFO
//   pop_tag      owner index of the FIFO head entry
//   pop_tag_vld  tag queue non-empty
//   tag_err      sticky tag-queue / FIFO occupancy mismatch
//
// DEPTH must be a power of two (>= 2) so the tag pointers wrap naturally.
module fifo_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int QUOTA = 4,
  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNTW = $clog2(QUOTA + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  fifo_push,
  output logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  pop,
  output logic                  fifo_pop,
  output logic [TAGW-1:0]       pop_tag,
  output logic                  pop_tag_vld,
  output logic                  tag_err
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int OCCW = $clog2(DEPTH + 1);

  logic [TAGW-1:0] r_rr_ptr;
  logic [CNTW-1:0] r_cnt [NREQ];
  logic [TAGW-1:0] r_tag_mem [DEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [OCCW-1:0] r_occ;
  logic            r_tag_err;

  logic [NREQ-1:0] w_elig;
  logic            w_any;
  logic [TAGW-1:0] w_idx;
  logic [TAGW:0]   w_sum;
  logic [TAGW-1:0] w_cand;
  logic [NREQ-1:0] w_gnt;
  logic            w_vld;
  logic            w_pop;
  logic            w_pop_eff;
  logic [TAGW-1:0] w_tag_hd;

  // Eligibility looks only at req, fifo_full and the per-owner counts, so
  // pop never reaches gnt combinationally; a pop frees quota next cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req[i] & ~fifo_full & (r_cnt[i] < CNTW'(QUOTA));
    end
  end

  // Round-robin search from r_rr_ptr upward, wrapping at NREQ. The sum is one
  // bit wider than a tag so rr_ptr + k never overflows before the wrap.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (TAGW+1)'(k);
      if (w_sum >= (TAGW+1)'(NREQ)) begin
        w_sum = w_sum - (TAGW+1)'(NREQ);
      end
      w_cand = w_sum[TAGW-1:0];
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  // Outputs are forced quiet while rst is held, whatever the inputs do.
  always_comb begin
    w_gnt = '0;
    if (w_any && !rst) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        fifo_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign gnt         = w_gnt;
  assign fifo_push   = |w_gnt;
  assign w_vld       = (r_occ != '0);
  assign w_pop       = pop & ~fifo_empty & ~rst;
  // A pop with no tag queued is flagged but must not move the tag state.
  assign w_pop_eff   = w_pop & w_vld;
  assign w_tag_hd    = r_tag_mem[r_rd_ptr];
  assign fifo_pop    = w_pop;
  assign pop_tag     = rst ? '0 : w_tag_hd;
  assign pop_tag_vld = w_vld & ~rst;
  assign tag_err     = r_tag_err;

  // Tag storage is plain data: written on push, never cleared.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      r_tag_mem[r_wr_ptr] <= w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_tag_err <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (fifo_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_idx == TAGW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (w_pop_eff) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // Push and pop together leave occupancy alone; saturate at DEPTH.
      case ({fifo_push, w_pop_eff})
        2'b10: if (r_occ != OCCW'(DEPTH)) r_occ <= r_occ + 1'b1;
        2'b01: r_occ <= r_occ - 1'b1;
        default: ;
      endcase

      // Grant and pop of the same owner in one cycle cancel out.
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && !(w_pop_eff && (w_tag_hd == TAGW'(i)))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_gnt[i] && w_pop_eff && (w_tag_hd == TAGW'(i))
                     && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end

      if ((w_vld == fifo_empty) || (w_pop && !w_vld) ||
          (fifo_push && !w_pop_eff && (r_occ == OCCW'(DEPTH)))) begin
        r_tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_share_arbiter.md
FIFO_SHARE_ARBITER -- requirements
Module: fifo_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of one FIFO entry.
REQ-002 Parameter NREQ, default 4, number of push requesters (2..8).
REQ-003 Parameter DEPTH, default 8, entries in the shared FIFO; power of two, equal to the attached FIFO's DEPTH.
REQ-004 Parameter QUOTA, default 4, max entries any one requester may hold in the FIFO (1..DEPTH).
REQ-005 Derived TAGW = max(1, clog2(NREQ)); CNTW = clog2(QUOTA+1).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req  input  NREQ  per-requester push request.
REQ-009 req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-010 gnt  output  NREQ  one-hot-or-zero; gnt[i]=1 means req_data i is pushed this cycle.
REQ-011 fifo_push  output  1  push strobe to shared FIFO.
REQ-012 fifo_data  output  WIDTH  data to shared FIFO.
REQ-013 fifo_full  input  1  full flag from shared FIFO.
REQ-014 fifo_empty  input  1  empty flag from shared FIFO.
REQ-015 pop  input  1  consumer pop request.
REQ-016 fifo_pop  output  1  pop strobe to shared FIFO.
REQ-017 pop_tag  output  TAGW  owner index of the FIFO head entry.
REQ-018 pop_tag_vld  output  1  tag queue non-empty.
REQ-019 tag_err  output  1  sticky tag-queue/FIFO occupancy mismatch flag.

Function
REQ-020 Grant eligibility for i: req[i] & !fifo_full & cnt[i] < QUOTA.
REQ-021 Grant is combinational, same cycle; at most one gnt bit set; fifo_push = |gnt; fifo_data = req_data of granted requester, 0 when no grant.
REQ-022 Round-robin: search eligible requesters starting at rr_ptr, ascending, wrapping at NREQ; first eligible wins.
REQ-023 On grant to i, rr_ptr <= (i+1) mod NREQ next edge; rr_ptr holds when no grant.
REQ-024 fifo_full blocks all grants even if fifo_pop asserts same cycle.
REQ-025 fifo_pop = pop & !fifo_empty; pop while empty is ignored, no state change.
REQ-026 Internal tag queue, DEPTH entries of TAGW bits, own wr/rd pointers (clog2(DEPTH) bits, wrap naturally) plus occupancy count 0..DEPTH.
REQ-027 On fifo_push write granted index into tag queue; on fifo_pop advance read pointer.
REQ-028 pop_tag = tag at read pointer, combinational; pop_tag_vld = tag occupancy != 0.
REQ-029 cnt[i] increments on gnt[i], decrements on fifo_pop with pop_tag==i; both same cycle on same i -> unchanged.
REQ-030 Simultaneous push and pop: tag occupancy unchanged, both pointers advance.
REQ-031 tag_err sets when pop_tag_vld == fifo_empty (both sampled at edge), or fifo_pop with tag occupancy 0, or tag occupancy would exceed DEPTH; cleared only by reset.
REQ-032 No combinational path from pop to gnt; gnt depends on req, fifo_full, cnt, rr_ptr only.

Reset
REQ-033 rst asserted: immediately rr_ptr=0, all cnt=0, tag pointers/occupancy=0, tag_err=0.
REQ-034 During rst: gnt=0, fifo_push=0, fifo_pop=0, pop_tag_vld=0, pop_tag=0 regardless of inputs.
REQ-035 Reset mid-operation discards all tags; the attached FIFO shares rst so both restart empty.
REQ-036 First grant possible in the first cycle after rst deasserts.

Verification
REQ-037 NREQ=4, all req high, no pop, 4 cycles -> gnt 0001,0010,0100,1000; tags 0,1,2,3 queued.
REQ-038 QUOTA=2, only req[1] high, 3 cycles -> grants cycles 1-2, none cycle 3; cnt[1]=2; one pop -> grant resumes next cycle.
REQ-039 DEPTH=8 filled (fifo_full=1), req[0] high and pop same cycle -> gnt=0, fifo_pop=1, cnt of popped owner decrements.
REQ-040 Empty FIFO, pop=1 -> fifo_pop=0, pointers and counters unchanged, tag_err=0.
REQ-041 Push by req 2 and pop of head tag 2 same cycle -> cnt[2] unchanged, tag occupancy unchanged, tag pointers wrap correctly past DEPTH after 10 such cycles.
REQ-042 rst asserted asynchronously mid-burst with 5 entries queued -> gnt, fifo_push, pop_tag_vld drop to 0 before next edge; all counters 0 after release.
